// File: rtl/rs_encoder_15_11_pkg.sv
// Shared constants, types and GF(16) arithmetic for the RS(15,11) encoder.
package rs_pkg;

    localparam int N     = 15;
    localparam int K     = 11;
    localparam int SYM_W = 4;
    localparam int NPAR  = N - K;

    // Primitive polynomial x^4 + x + 1
    localparam logic [SYM_W:0] PRIM_POLY = 5'h13;

    typedef logic [SYM_W-1:0] sym_t;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
    localparam sym_t G3 = 4'hD;
    localparam sym_t G2 = 4'hC;
    localparam sym_t G1 = 4'h8;
    localparam sym_t G0 = 4'h7;

    localparam logic [3:0] LAST_MSG = 4'(K - 1);
    localparam logic [1:0] LAST_PAR = 2'(NPAR - 1);

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    // Shift-and-add multiply with reduction by the primitive polynomial
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            if (x[SYM_W-1]) begin
                x = {x[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0];
            end else begin
                x = {x[SYM_W-2:0], 1'b0};
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_encoder_15_11_if.sv
// Streaming handshake bundle: message symbols in, codeword symbols out.
interface rs_encoder_15_11_if;
    import rs_pkg::*;

    sym_t IN_SYM;
    logic IN_VALID;
    logic IN_READY;
    sym_t OUT_SYM;
    logic OUT_VALID;
    logic OUT_READY;
    logic OUT_LAST;

    // Encoder side
    modport slave (
        input  IN_SYM,
        input  IN_VALID,
        output IN_READY,
        output OUT_SYM,
        output OUT_VALID,
        input  OUT_READY,
        output OUT_LAST
    );

    // Source/sink side
    modport master (
        output IN_SYM,
        output IN_VALID,
        input  IN_READY,
        input  OUT_SYM,
        input  OUT_VALID,
        output OUT_READY,
        input  OUT_LAST
    );

endinterface

// File: rtl/rs_encoder_15_11_gf_mult.sv
// Combinational full GF(16) multiplier.
module full_GF_mult
    import rs_pkg::*;
(
    input  sym_t a_i,
    input  sym_t b_i,
    output sym_t p_o
);

    assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder over GF(16): passes the 11 message symbols
// through, then emits the 4 parity symbols (highest degree first).
module rs_encoder_15_11
    import rs_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    rs_encoder_15_11_if.slave   bus
);

    state_t                state_q,   state_d;
    logic [3:0]            msg_cnt_q, msg_cnt_d;
    logic [1:0]            par_cnt_q, par_cnt_d;
    sym_t [NPAR-1:0]       r_q,       r_d;
    sym_t                  out_sym_q,   out_sym_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;

    logic free;
    logic in_ready;
    logic in_xfer;
    sym_t fb;
    sym_t m3, m2, m1, m0;

    // Output register can take a new symbol when empty or being drained
    assign free     = !out_valid_q || bus.OUT_READY;
    assign in_ready = (state_q == ST_MSG) && free;
    assign in_xfer  = bus.IN_VALID && in_ready;
    assign fb       = bus.IN_SYM ^ r_q[NPAR-1];

    full_GF_mult u_mul3 (.a_i(fb), .b_i(G3), .p_o(m3));
    full_GF_mult u_mul2 (.a_i(fb), .b_i(G2), .p_o(m2));
    full_GF_mult u_mul1 (.a_i(fb), .b_i(G1), .p_o(m1));
    full_GF_mult u_mul0 (.a_i(fb), .b_i(G0), .p_o(m0));

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_SYM   = out_sym_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_LAST  = out_last_q;

    // Next-state: LFSR division during message, parity shift-out afterwards
    always_comb begin
        state_d     = state_q;
        msg_cnt_d   = msg_cnt_q;
        par_cnt_d   = par_cnt_q;
        r_d         = r_q;
        out_sym_d   = out_sym_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_MSG: begin
                if (in_xfer) begin
                    r_d[3]      = r_q[2] ^ m3;
                    r_d[2]      = r_q[1] ^ m2;
                    r_d[1]      = r_q[0] ^ m1;
                    r_d[0]      = m0;
                    out_sym_d   = bus.IN_SYM;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    if (msg_cnt_q == LAST_MSG) begin
                        msg_cnt_d = '0;
                        state_d   = ST_PAR;
                    end else begin
                        msg_cnt_d = msg_cnt_q + 4'd1;
                    end
                end else if (free) begin
                    // Nothing to send: register empties rather than repeating
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_PAR: begin
                if (free) begin
                    out_sym_d   = r_q[NPAR-1];
                    out_valid_d = 1'b1;
                    if (par_cnt_q == LAST_PAR) begin
                        // Final parity: leave the LFSR clean for the next frame
                        out_last_d = 1'b1;
                        par_cnt_d  = '0;
                        r_d        = '0;
                        state_d    = ST_MSG;
                    end else begin
                        out_last_d = 1'b0;
                        r_d        = {r_q[NPAR-2:0], sym_t'(0)};
                        par_cnt_d  = par_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_MSG;
            end
        endcase
    end

    // State, LFSR and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_MSG;
            msg_cnt_q   <= '0;
            par_cnt_q   <= '0;
            r_q         <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_cnt_q   <= msg_cnt_d;
            par_cnt_q   <= par_cnt_d;
            r_q         <= r_d;
            out_sym_q   <= out_sym_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Testbench for rs_encoder_15_11: vector table with scoreboard, syndrome
// checks on every codeword, stall stability, mid-frame reset and
// back-to-back throughput.
module tb_rs_encoder_15_11;

    typedef struct packed {
        logic [10:0][3:0] msg;
        logic [3:0][3:0]  par;
    } vec_t;

    typedef struct packed {
        logic [3:0] sym;
        logic       last;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    logic rdy_rand = 1'b0;

    int total = 0;
    int bad   = 0;

    exp_t sb [$];

    logic [3:0] gexp [15];
    int         glog [16];

    logic [3:0] cw [15];
    int         cw_n = 0;
    logic       stall_prev = 1'b0;
    logic [3:0] held_sym;
    logic       held_last;

    vec_t tbl [12];

    always #5 CLK = ~CLK;

    rs_encoder_15_11_if bus ();

    rs_encoder_15_11 dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void init_tables();
        logic [4:0] x;
        x = 5'd1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = x[3:0];
            glog[x[3:0]] = i;
            x = x << 1;
            if (x[4]) x = x ^ 5'h13;
        end
        glog[0] = 0;
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Polynomial long division of m(x)*x^4 by g(x); par[0] is the x^3 term
    function automatic logic [3:0][3:0] model_par(input logic [10:0][3:0] m);
        logic [3:0] c [15];
        logic [3:0] q;
        logic [3:0][3:0] p;
        for (int i = 0; i < 11; i++) c[14-i] = m[i];
        for (int i = 0; i < 4; i++) c[i] = 4'h0;
        for (int d = 14; d >= 4; d--) begin
            q = c[d];
            c[d-1] = c[d-1] ^ gmul(q, 4'hD);
            c[d-2] = c[d-2] ^ gmul(q, 4'hC);
            c[d-3] = c[d-3] ^ gmul(q, 4'h8);
            c[d-4] = c[d-4] ^ gmul(q, 4'h7);
            c[d] = 4'h0;
        end
        p[0] = c[3];
        p[1] = c[2];
        p[2] = c[1];
        p[3] = c[0];
        return p;
    endfunction

    // Drive nsym message symbols, pushing expectations on each transfer
    task automatic send_msg(input logic [10:0][3:0] m, input logic [3:0][3:0] p, input int nsym);
        int g;
        exp_t e;
        for (int i = 0; i < nsym; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_SYM   = m[i];
            g = 0;
            @(negedge CLK);
            while (!bus.IN_READY && g < 100) begin
                @(negedge CLK);
                g++;
            end
            if (!bus.IN_READY) chk("in_ready_timeout", 32'd0, 32'd1);
            e.sym  = m[i];
            e.last = 1'b0;
            sb.push_back(e);
            @(posedge CLK);
            #1;
        end
        if (nsym == 11) begin
            for (int j = 0; j < 4; j++) begin
                e.sym  = p[j];
                e.last = (j == 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic b2b_check();
        int g;
        int vcnt;
        int mis;
        logic exp_rdy;
        g = 0;
        vcnt = 0;
        mis = 0;
        @(negedge CLK);
        while (!bus.OUT_VALID && g < 50) begin
            @(negedge CLK);
            g++;
        end
        for (int i = 0; i < 30; i++) begin
            if (bus.OUT_VALID) vcnt++;
            exp_rdy = !(((i % 15) >= 10) && ((i % 15) <= 13));
            if (bus.IN_READY !== exp_rdy) mis++;
            if (i < 29) @(negedge CLK);
        end
        chk("b2b_valid_count", 32'(vcnt), 32'd30);
        chk("b2b_in_ready_pattern_errors", 32'(mis), 32'd0);
    endtask

    // Downstream ready: held high or randomly stalling
    initial begin
        bus.OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_rand) bus.OUT_READY = ($urandom_range(0, 2) != 0);
            else          bus.OUT_READY = 1'b1;
        end
    end

    // Output monitor: scoreboard pop, stall stability, codeword syndromes
    initial begin
        exp_t e;
        logic [3:0] s;
        logic [3:0] ak;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                stall_prev = 1'b0;
                cw_n = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid_held", 32'(bus.OUT_VALID), 32'd1);
                    chk("stall_sym_held", 32'(bus.OUT_SYM), 32'(held_sym));
                    chk("stall_last_held", 32'(bus.OUT_LAST), 32'(held_last));
                end
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(bus.OUT_SYM), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("out_sym", 32'(bus.OUT_SYM), 32'(e.sym));
                        chk("out_last", 32'(bus.OUT_LAST), 32'(e.last));
                    end
                    cw[cw_n] = bus.OUT_SYM;
                    cw_n++;
                    if (cw_n == 15) begin
                        for (int k = 1; k <= 4; k++) begin
                            ak = gexp[k];
                            s = 4'h0;
                            for (int j = 0; j < 15; j++) s = gmul(s, ak) ^ cw[j];
                            chk($sformatf("syndrome_a%0d", k), 32'(s), 32'd0);
                        end
                        cw_n = 0;
                    end
                end
                stall_prev = bus.OUT_VALID && !bus.OUT_READY;
                held_sym   = bus.OUT_SYM;
                held_last  = bus.OUT_LAST;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [10:0][3:0] m;
        logic [3:0][3:0]  p;

        init_tables();
        RESET        = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_SYM   = 4'h0;

        // Vector table: fixed known codewords, then random messages
        v = '0;
        tbl[0] = v;
        v = '0; v.msg[10] = 4'h1;
        v.par[0] = 4'hD; v.par[1] = 4'hC; v.par[2] = 4'h8; v.par[3] = 4'h7;
        tbl[1] = v;
        v = '0; v.msg[10] = 4'h3;
        v.par[0] = 4'h4; v.par[1] = 4'h7; v.par[2] = 4'hB; v.par[3] = 4'h9;
        tbl[2] = v;
        v = '0; v.msg[9] = 4'h1;
        v.par[0] = 4'h2; v.par[1] = 4'hB; v.par[2] = 4'h5; v.par[3] = 4'h5;
        tbl[3] = v;
        for (int i = 4; i < 12; i++) begin
            for (int j = 0; j < 11; j++) v.msg[j] = 4'($urandom_range(0, 15));
            v.par = model_par(v.msg);
            tbl[i] = v;
        end

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("reset_out_last", 32'(bus.OUT_LAST), 32'd0);
        chk("reset_out_sym", 32'(bus.OUT_SYM), 32'd0);
        chk("reset_in_ready", 32'(bus.IN_READY), 32'd1);

        // Table: even entries unstalled, odd entries with random stalls
        for (int i = 0; i < 12; i++) begin
            rdy_rand = (i % 2 == 1);
            send_msg(tbl[i].msg, tbl[i].par, 11);
            bus.IN_VALID = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end
        wait_drain();
        rdy_rand = 1'b0;
        @(posedge CLK);
        #1;

        // Reset after 6 symbols, then a clean unit frame
        send_msg(tbl[5].msg, tbl[5].par, 6);
        bus.IN_VALID = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("midreset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("midreset_out_last", 32'(bus.OUT_LAST), 32'd0);
        chk("midreset_in_ready", 32'(bus.IN_READY), 32'd1);
        sb.delete();
        send_msg(tbl[1].msg, tbl[1].par, 11);
        bus.IN_VALID = 1'b0;
        wait_drain();

        // Two frames back to back at full rate
        for (int j = 0; j < 11; j++) m[j] = 4'($urandom_range(0, 15));
        p = model_par(m);
        fork
            begin
                send_msg(m, p, 11);
                send_msg(tbl[6].msg, tbl[6].par, 11);
                bus.IN_VALID = 1'b0;
            end
            begin
                b2b_check();
            end
        join
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
